vga_timing_pattern_gen: RTL

Parametrised successor to the fixed sync-pulse/test-pattern pair. It generates full raster timing with configurable front porch, sync width and sync polarity, and drives a selectable multi-mode test pattern. Outputs are aligned and registered. Pattern selection is frame-synchronous, so a frame never mixes two patterns. The block sits at the head of the video path and feeds the DAC or the vga_logger in simulation.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_timing_counters.sv | 61 ++++++
 rtl/vga_timing_pattern_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared pattern codes, colour-bar table and width helper for the VGA timing/pattern generator.
package vga_timing_pkg;

   localparam logic [3:0] PAT_BLACK   = 4'd0;
   localparam logic [3:0] PAT_SOLID   = 4'd1;
   localparam logic [3:0] PAT_BARS    = 4'd2;
   localparam logic [3:0] PAT_CHECKER = 4'd3;
   localparam logic [3:0] PAT_HRAMP   = 4'd4;
   localparam logic [3:0] PAT_VRAMP   = 4'd5;
   localparam logic [3:0] PAT_BORDER  = 4'd6;

   // {R,G,B} masks, index 0 = white ... index 7 = black
   localparam logic [7:0][2:0] BAR_TABLE = {
      3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
   };

   // Bits needed to hold 0..value-1, never less than one
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/vga_timing_counters.sv
// Raster column/row counters with unregistered sync windows, active flag and frame-start detect.
module vga_timing_counters
   import vga_timing_pkg::*;
#(
   parameter int unsigned TOTAL_COLS    = 384,
   parameter int unsigned TOTAL_ROWS    = 288,
   parameter int unsigned ACTIVE_COLS   = 288,
   parameter int unsigned ACTIVE_ROWS   = 224,
   parameter int unsigned H_FRONT_PORCH = 16,
   parameter int unsigned H_SYNC_WIDTH  = 32,
   parameter int unsigned V_FRONT_PORCH = 8,
   parameter int unsigned V_SYNC_WIDTH  = 3,
   localparam int unsigned COL_W        = clog2(TOTAL_COLS),
   localparam int unsigned ROW_W        = clog2(TOTAL_ROWS)
) (
   input  logic             i_Clk,
   input  logic             i_Rst_n,
   output logic [COL_W-1:0] o_Col_c,
   output logic [ROW_W-1:0] o_Row_c,
   output logic             o_HSync_c,
   output logic             o_VSync_c,
   output logic             o_Active_c,
   output logic             o_Frame_Start_c,
   output logic             o_Col_Last_c
);

   localparam int unsigned HS_START = ACTIVE_COLS + H_FRONT_PORCH;
   localparam int unsigned HS_END   = HS_START + H_SYNC_WIDTH;
   localparam int unsigned VS_START = ACTIVE_ROWS + V_FRONT_PORCH;
   localparam int unsigned VS_END   = VS_START + V_SYNC_WIDTH;

   logic [COL_W-1:0] r_Col;
   logic [ROW_W-1:0] r_Row;
   logic             w_Col_Last;
   logic             w_Row_Last;

   assign w_Col_Last = (r_Col == COL_W'(TOTAL_COLS - 1));
   assign w_Row_Last = (r_Row == ROW_W'(TOTAL_ROWS - 1));

   // Row advances only on column wrap
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Col <= '0;
         r_Row <= '0;
      end else if (w_Col_Last) begin
         r_Col <= '0;
         r_Row <= w_Row_Last ? '0 : r_Row + ROW_W'(1);
      end else begin
         r_Col <= r_Col + COL_W'(1);
      end
   end

   assign o_Col_c         = r_Col;
   assign o_Row_c         = r_Row;
   assign o_Col_Last_c    = w_Col_Last;
   assign o_HSync_c       = (32'(r_Col) >= HS_START) && (32'(r_Col) < HS_END);
   assign o_VSync_c       = (32'(r_Row) >= VS_START) && (32'(r_Row) < VS_END);
   assign o_Active_c      = (32'(r_Col) < ACTIVE_COLS) && (32'(r_Row) < ACTIVE_ROWS);
   assign o_Frame_Start_c = (r_Col == '0) && (r_Row == '0);

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// VGA raster timing plus frame-synchronous multi-mode test pattern, all outputs registered and aligned.
module vga_timing_pattern_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned VIDEO_WIDTH      = 3,
   parameter int unsigned TOTAL_COLS       = 384,
   parameter int unsigned TOTAL_ROWS       = 288,
   parameter int unsigned ACTIVE_COLS      = 288,
   parameter int unsigned ACTIVE_ROWS      = 224,
   parameter int unsigned H_FRONT_PORCH    = 16,
   parameter int unsigned H_SYNC_WIDTH     = 32,
   parameter int unsigned V_FRONT_PORCH    = 8,
   parameter int unsigned V_SYNC_WIDTH     = 3,
   parameter bit          SYNC_ACTIVE_HIGH = 1'b0,
   parameter int unsigned CHECK_SHIFT      = 3,
   parameter int unsigned RAMP_SHIFT       = 0,
   localparam int unsigned COL_W           = clog2(TOTAL_COLS),
   localparam int unsigned ROW_W           = clog2(TOTAL_ROWS),
   localparam int unsigned RGB_W           = 3 * VIDEO_WIDTH
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_n,
   input  logic [3:0]             i_Pattern,
   input  logic [RGB_W-1:0]       i_Solid_RGB,
   output logic                   o_HSync,
   output logic                   o_VSync,
   output logic                   o_Active,
   output logic                   o_Frame_Start,
   output logic [COL_W-1:0]       o_Col,
   output logic [ROW_W-1:0]       o_Row,
   output logic [VIDEO_WIDTH-1:0] o_Red_Video,
   output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
   output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

   localparam int unsigned BAR_W  = ACTIVE_COLS >> 3;
   localparam int unsigned BAR_CW = clog2(BAR_W);
   localparam logic        SYNC_ON = SYNC_ACTIVE_HIGH;

   logic [COL_W-1:0]  w_Col;
   logic [ROW_W-1:0]  w_Row;
   logic              w_HSync;
   logic              w_VSync;
   logic              w_Active;
   logic              w_Frame_Start;
   logic              w_Col_Last;

   logic [3:0]        r_Pattern;
   logic [RGB_W-1:0]  r_Solid;
   logic [BAR_CW-1:0] r_Bar_Cnt;
   logic [3:0]        r_Bar_Idx;

   logic [3:0]        w_Pattern;
   logic [RGB_W-1:0]  w_Solid;
   logic [2:0]        w_Bar_Mask;
   logic [RGB_W-1:0]  w_Rgb;

   logic              r_HSync;
   logic              r_VSync;
   logic              r_Active;
   logic              r_Frame_Start;
   logic [COL_W-1:0]  r_Col;
   logic [ROW_W-1:0]  r_Row;
   logic [RGB_W-1:0]  r_Rgb;

   vga_timing_counters #(
      .TOTAL_COLS    (TOTAL_COLS),
      .TOTAL_ROWS    (TOTAL_ROWS),
      .ACTIVE_COLS   (ACTIVE_COLS),
      .ACTIVE_ROWS   (ACTIVE_ROWS),
      .H_FRONT_PORCH (H_FRONT_PORCH),
      .H_SYNC_WIDTH  (H_SYNC_WIDTH),
      .V_FRONT_PORCH (V_FRONT_PORCH),
      .V_SYNC_WIDTH  (V_SYNC_WIDTH)
   ) u_counters (
      .i_Clk           (i_Clk),
      .i_Rst_n         (i_Rst_n),
      .o_Col_c         (w_Col),
      .o_Row_c         (w_Row),
      .o_HSync_c       (w_HSync),
      .o_VSync_c       (w_VSync),
      .o_Active_c      (w_Active),
      .o_Frame_Start_c (w_Frame_Start),
      .o_Col_Last_c    (w_Col_Last)
   );

   // Pixel (0,0) already uses the freshly sampled selection
   assign w_Pattern = w_Frame_Start ? i_Pattern   : r_Pattern;
   assign w_Solid   = w_Frame_Start ? i_Solid_RGB : r_Solid;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Pattern <= '0;
         r_Solid   <= '0;
      end else if (w_Frame_Start) begin
         r_Pattern <= i_Pattern;
         r_Solid   <= i_Solid_RGB;
      end
   end

   // Bar index tracks the column counter; saturates at 8 past the last full bar
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Bar_Cnt <= '0;
         r_Bar_Idx <= '0;
      end else if (w_Col_Last) begin
         r_Bar_Cnt <= '0;
         r_Bar_Idx <= '0;
      end else if (r_Bar_Idx != 4'd8) begin
         if (r_Bar_Cnt == BAR_CW'(BAR_W - 1)) begin
            r_Bar_Cnt <= '0;
            r_Bar_Idx <= r_Bar_Idx + 4'd1;
         end else begin
            r_Bar_Cnt <= r_Bar_Cnt + BAR_CW'(1);
         end
      end
   end

   always_comb begin
      w_Rgb      = '0;
      w_Bar_Mask = BAR_TABLE[r_Bar_Idx[2:0]];
      case (w_Pattern)
         PAT_SOLID:   w_Rgb = w_Solid;
         PAT_BARS:
            if (!r_Bar_Idx[3])
               w_Rgb = {{VIDEO_WIDTH{w_Bar_Mask[2]}},
                        {VIDEO_WIDTH{w_Bar_Mask[1]}},
                        {VIDEO_WIDTH{w_Bar_Mask[0]}}};
         PAT_CHECKER:
            if (w_Col[CHECK_SHIFT] ^ w_Row[CHECK_SHIFT]) w_Rgb = '1;
         PAT_HRAMP:   w_Rgb = {3{w_Col[RAMP_SHIFT +: VIDEO_WIDTH]}};
         PAT_VRAMP:   w_Rgb = {3{w_Row[RAMP_SHIFT +: VIDEO_WIDTH]}};
         PAT_BORDER:
            if ((w_Col == '0) || (w_Col == COL_W'(ACTIVE_COLS - 1)) ||
                (w_Row == '0) || (w_Row == ROW_W'(ACTIVE_ROWS - 1)))
               w_Rgb = '1;
         default:     w_Rgb = '0;
      endcase
      if (!w_Active) w_Rgb = '0;
   end

   // Output stage: one cycle after the counter state it describes
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_HSync       <= ~SYNC_ON;
         r_VSync       <= ~SYNC_ON;
         r_Active      <= 1'b0;
         r_Frame_Start <= 1'b0;
         r_Col         <= '0;
         r_Row         <= '0;
         r_Rgb         <= '0;
      end else begin
         r_HSync       <= w_HSync ? SYNC_ON : ~SYNC_ON;
         r_VSync       <= w_VSync ? SYNC_ON : ~SYNC_ON;
         r_Active      <= w_Active;
         r_Frame_Start <= w_Frame_Start;
         r_Col         <= w_Col;
         r_Row         <= w_Row;
         r_Rgb         <= w_Rgb;
      end
   end

   assign o_HSync       = r_HSync;
   assign o_VSync       = r_VSync;
   assign o_Active      = r_Active;
   assign o_Frame_Start = r_Frame_Start;
   assign o_Col         = r_Col;
   assign o_Row         = r_Row;
   assign o_Red_Video   = r_Rgb[3*VIDEO_WIDTH-1 -: VIDEO_WIDTH];
   assign o_Grn_Video   = r_Rgb[2*VIDEO_WIDTH-1 -: VIDEO_WIDTH];
   assign o_Blu_Video   = r_Rgb[VIDEO_WIDTH-1   -: VIDEO_WIDTH];

endmodule
